// File: rtl/fp_pkg.sv
// fp_pkg: GRS bit positions, stage record and pipeline sizing helper for the FP adder alignment path
package fp_pkg;

    localparam int GRS_G = 2;
    localparam int GRS_R = 1;
    localparam int GRS_S = 0;

    localparam int DEF_WIDTH = 24;
    localparam int DEF_TAG_W = 4;

    // Number of binary-weighted shift stages needed to cover a {sig, g, r, s} word
    function automatic int nstg(input int width);
        return $clog2(width + 3);
    endfunction

    localparam int DEF_NSTG = nstg(DEF_WIDTH);

    // Stage record at the default configuration; the top declares the same layout at its own widths
    typedef struct packed {
        logic [DEF_WIDTH-1:0] sig;
        logic [2:0]           grs;
        logic [DEF_TAG_W-1:0] tag;
        logic [DEF_NSTG-1:0]  shamt_rem;
        logic                 valid;
    } stage_t;

endpackage

// File: rtl/align_shifter_if.sv
// align_shifter_if: input beat channel and result channel of the alignment shifter
interface align_shifter_if #(
    parameter int WIDTH   = 24,
    parameter int SHAMT_W = 8,
    parameter int TAG_W   = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_sig;
    logic [SHAMT_W-1:0] in_shamt;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_sig;
    logic [2:0]         out_grs;
    logic [TAG_W-1:0]   out_tag;

    modport master (
        output in_valid, in_sig, in_shamt, in_tag, out_ready,
        input  in_ready, out_valid, out_sig, out_grs, out_tag
    );

    modport slave (
        input  in_valid, in_sig, in_shamt, in_tag, out_ready,
        output in_ready, out_valid, out_sig, out_grs, out_tag
    );
endinterface

// File: rtl/align_shift_stage.sv
// align_shift_stage: one conditional right shift by 2^K with sticky fold (ALIGN_SHIFT_STICKY_FULL_EN)
module align_shift_stage
    import fp_pkg::*;
#(
    parameter int W3 = 27,
    parameter int NS = 5,
    parameter int K  = 0
) (
    input  logic [W3-1:0] in_word,
    input  logic [NS-1:0] in_shamt,
    output logic [W3-1:0] out_word,
    output logic [NS-1:0] out_shamt
);
    localparam int SH = 1 << K;

    // Shift when the lowest pending amount bit is set; full sticky ORs everything landing at or below s
    always_comb begin
        out_word = in_shamt[0] ? in_word >> SH : in_word;
`ifdef ALIGN_SHIFT_STICKY_FULL_EN
        out_word[GRS_S] = in_shamt[0] ? |in_word[SH:0] : in_word[GRS_S];
`endif
        out_shamt = in_shamt >> 1;
    end
endmodule

// File: rtl/align_shifter.sv
// align_shifter: pipelined right-alignment shifter producing guard/round/sticky; ALIGN_SHIFT_STICKY_FULL_EN selects full sticky
module align_shifter
    import fp_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int SHAMT_W   = 8,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 4
) (
    input logic            clk,
    input logic            rst_n,
    align_shifter_if.slave bus
);
    localparam int NSTG = nstg(WIDTH);
    localparam int W3   = WIDTH + 3;

    typedef struct packed {
        logic [WIDTH-1:0] sig;
        logic [2:0]       grs;
        logic [TAG_W-1:0] tag;
        logic [NSTG-1:0]  shamt_rem;
        logic             valid;
    } rec_t;

    rec_t entry;
    logic stall;
    logic sat;
    logic sat_s;

    // Saturating amounts are resolved here so the stages only ever see in-range shifts
    always_comb begin
        sat = 32'(bus.in_shamt) >= WIDTH + 2;
`ifdef ALIGN_SHIFT_STICKY_FULL_EN
        sat_s = |bus.in_sig;
`else
        sat_s = (32'(bus.in_shamt) == WIDTH + 2) & bus.in_sig[WIDTH-1];
`endif
        entry.sig       = sat ? '0 : bus.in_sig;
        entry.grs       = sat ? {2'b00, sat_s} : 3'b000;
        entry.tag       = bus.in_tag;
        entry.shamt_rem = sat ? '0 : bus.in_shamt[NSTG-1:0];
        entry.valid     = bus.in_valid;
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        rec_t            si;
        rec_t            so;
        logic [W3-1:0]   word_o;
        logic [NSTG-1:0] shamt_o;

        if (k == 0) begin : g_src
            // First stage is fed straight from the input beat
            always_comb si = entry;
        end else if (k % REG_EVERY == 0) begin : g_src
            // Previous stage ended on a register boundary
            always_comb si = g_stg[k-1].g_reg.pipe_q;
        end else begin : g_src
            // Previous stage is chained combinationally
            always_comb si = g_stg[k-1].so;
        end

        align_shift_stage #(.W3(W3), .NS(NSTG), .K(k)) u_stage (
            .in_word   ({si.sig, si.grs}),
            .in_shamt  (si.shamt_rem),
            .out_word  (word_o),
            .out_shamt (shamt_o)
        );

        // Tag and valid ride along untouched; shifted word and remaining amount come from the stage
        always_comb begin
            so = si;
            {so.sig, so.grs} = word_o;
            so.shamt_rem = shamt_o;
        end

        if ((k + 1) % REG_EVERY == 0 || k == NSTG - 1) begin : g_reg
            rec_t pipe_d;
            rec_t pipe_q;
            // Global stall freezes every register, valids included; otherwise bubbles advance too
            always_comb pipe_d = stall ? pipe_q : so;
            // Reset clears valid and zeroes data so the outputs read zero out of reset
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) pipe_q <= '0;
                else        pipe_q <= pipe_d;
            end
        end
    end

    // Output channel is the last register; in_ready is the only combinational path, from out_ready
    always_comb begin
        stall         = g_stg[NSTG-1].g_reg.pipe_q.valid & ~bus.out_ready;
        bus.in_ready  = ~stall;
        bus.out_valid = g_stg[NSTG-1].g_reg.pipe_q.valid;
        bus.out_sig   = g_stg[NSTG-1].g_reg.pipe_q.sig;
        bus.out_grs   = {g_stg[NSTG-1].g_reg.pipe_q.grs[GRS_G],
                         g_stg[NSTG-1].g_reg.pipe_q.grs[GRS_R],
                         g_stg[NSTG-1].g_reg.pipe_q.grs[GRS_S]};
        bus.out_tag   = g_stg[NSTG-1].g_reg.pipe_q.tag;
    end
endmodule

// File: tb/tb_align_shifter.sv
// tb_align_shifter: directed and streaming checks of align_shifter latency, GRS, flow control and reset
module tb_align_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;

    align_shifter_if #(.WIDTH(24), .SHAMT_W(8), .TAG_W(4)) bus ();

    align_shifter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

`ifdef ALIGN_SHIFT_STICKY_FULL_EN
    localparam logic [2:0] G_11_5   = 3'b101;
    localparam logic [2:0] G_1_30   = 3'b001;
    localparam logic [2:0] G_40_26  = 3'b001;
    localparam logic [2:0] G_FF_255 = 3'b001;
    localparam logic [2:0] G_1234_8 = 3'b011;
`else
    localparam logic [2:0] G_11_5   = 3'b100;
    localparam logic [2:0] G_1_30   = 3'b000;
    localparam logic [2:0] G_40_26  = 3'b000;
    localparam logic [2:0] G_FF_255 = 3'b000;
    localparam logic [2:0] G_1234_8 = 3'b010;
`endif

    typedef struct {
        logic [23:0] sig;
        logic [7:0]  sh;
        logic [23:0] esig;
        logic [2:0]  egrs;
    } vec_t;

    // Infinite-precision reference: shift into a wide zero-padded word and read the discarded bits
    function automatic logic [26:0] model(input logic [23:0] sig, input logic [7:0] sh);
        logic [279:0] w;
        logic s;
        w = {sig, 256'd0} >> sh;
`ifdef ALIGN_SHIFT_STICKY_FULL_EN
        s = |w[253:0];
`else
        s = w[253];
`endif
        return {w[279:256], w[255], w[254], s};
    endfunction

    task automatic drive(input logic v, input logic [23:0] s, input logic [7:0] sh, input logic [3:0] t);
        bus.in_valid = v;
        bus.in_sig   = s;
        bus.in_shamt = sh;
        bus.in_tag   = t;
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_out_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_sig !== 24'h0) begin n_fail++; $display("FAIL post_rst_out_sig got %h want 0", bus.out_sig); end
        n_checks++; if (bus.out_grs !== 3'b000) begin n_fail++; $display("FAIL post_rst_out_grs got %b want 000", bus.out_grs); end
        n_checks++; if (bus.out_tag !== 4'h0) begin n_fail++; $display("FAIL post_rst_out_tag got %h want 0", bus.out_tag); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_directed();
        vec_t v [10];
        int cnt;
        v = '{
            '{24'h800001, 8'd3,   24'h100000, 3'b001},
            '{24'hABCDEF, 8'd0,   24'hABCDEF, 3'b000},
            '{24'h000011, 8'd5,   24'h000000, G_11_5},
            '{24'h000001, 8'd30,  24'h000000, G_1_30},
            '{24'hFFFFFF, 8'd1,   24'h7FFFFF, 3'b100},
            '{24'h400000, 8'd26,  24'h000000, G_40_26},
            '{24'h800000, 8'd25,  24'h000000, 3'b010},
            '{24'hFFFFFF, 8'd255, 24'h000000, G_FF_255},
            '{24'h123456, 8'd8,   24'h001234, G_1234_8},
            '{24'hFFFFFF, 8'd24,  24'h000000, 3'b111}
        };
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            drive(1'b1, v[i].sig, v[i].sh, 4'(i));
            cnt = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk); #1;
                bus.in_valid = 1'b0;
                cnt++;
                if (bus.out_valid) break;
            end
            n_checks++; if (cnt !== 3) begin n_fail++; $display("FAIL dir%0d_latency got %0d want 3", i, cnt); end
            n_checks++; if (bus.out_sig !== v[i].esig) begin n_fail++; $display("FAIL dir%0d_sig got %h want %h", i, bus.out_sig, v[i].esig); end
            n_checks++; if (bus.out_grs !== v[i].egrs) begin n_fail++; $display("FAIL dir%0d_grs got %b want %b", i, bus.out_grs, v[i].egrs); end
            n_checks++; if (bus.out_tag !== 4'(i)) begin n_fail++; $display("FAIL dir%0d_tag got %h want %h", i, bus.out_tag, 4'(i)); end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] s_in [16];
        logic [7:0]  sh_in [16];
        logic [26:0] ex;
        int got = 0;
        int first = -1;
        int last = -1;
        for (int i = 0; i < 16; i++) begin
            s_in[i]  = 24'($urandom);
            sh_in[i] = (i % 5 == 4) ? 8'($urandom_range(26, 255)) : 8'($urandom_range(0, 27));
        end
        bus.out_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk); #1;
            if (bus.out_valid) begin
                if (first < 0) first = c;
                last = c;
                n_checks++;
                if (got >= 16) begin
                    n_fail++; $display("FAIL b2b_extra got beat tag %h want none", bus.out_tag);
                end else begin
                    ex = model(s_in[got], sh_in[got]);
                    if ({bus.out_sig, bus.out_grs, bus.out_tag} !== {ex, 4'(got)}) begin
                        n_fail++;
                        $display("FAIL b2b_beat%0d got %h/%b/%h want %h/%b/%h", got, bus.out_sig, bus.out_grs, bus.out_tag, ex[26:3], ex[2:0], 4'(got));
                    end
                end
                got++;
            end
            if (c < 16) drive(1'b1, s_in[c], sh_in[c], 4'(c));
            else        bus.in_valid = 1'b0;
        end
        n_checks++; if (first !== 3) begin n_fail++; $display("FAIL b2b_first got %0d want 3", first); end
        n_checks++; if (got !== 16) begin n_fail++; $display("FAIL b2b_count got %0d want 16", got); end
        n_checks++; if (last - first !== 15) begin n_fail++; $display("FAIL b2b_span got %0d want 15", last - first); end
    endtask

    task automatic test_stall();
        logic [23:0] s_in [8];
        logic [7:0]  sh_in [8];
        logic [26:0] ex;
        int sent = 0;
        int popped = 0;
        for (int i = 0; i < 8; i++) begin
            s_in[i]  = 24'($urandom);
            sh_in[i] = 8'($urandom_range(0, 26));
        end
        for (int c = 0; c < 40 && popped < 8; c++) begin
            @(negedge clk);
            bus.out_ready = (c >= 8);
            if (sent < 8) drive(1'b1, s_in[sent], sh_in[sent], 4'(sent + 3));
            else          bus.in_valid = 1'b0;
            #1;
            if (c >= 3 && c < 8) begin
                ex = model(s_in[0], sh_in[0]);
                n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready c%0d got %b want 0", c, bus.in_ready); end
                n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid c%0d got %b want 1", c, bus.out_valid); end
                n_checks++;
                if ({bus.out_sig, bus.out_grs, bus.out_tag} !== {ex, 4'd3}) begin
                    n_fail++; $display("FAIL stall_hold c%0d got %h/%b/%h want %h/%b/3", c, bus.out_sig, bus.out_grs, bus.out_tag, ex[26:3], ex[2:0]);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                ex = model(s_in[popped], sh_in[popped]);
                n_checks++;
                if ({bus.out_sig, bus.out_grs, bus.out_tag} !== {ex, 4'(popped + 3)}) begin
                    n_fail++;
                    $display("FAIL stall_pop%0d got %h/%b/%h want %h/%b/%h", popped, bus.out_sig, bus.out_grs, bus.out_tag, ex[26:3], ex[2:0], 4'(popped + 3));
                end
                popped++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        bus.in_valid = 1'b0;
        n_checks++; if (popped !== 8) begin n_fail++; $display("FAIL stall_popped got %0d want 8", popped); end
        n_checks++; if (sent !== 8) begin n_fail++; $display("FAIL stall_sent got %0d want 8", sent); end
        @(negedge clk); #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_drained got %b want 0", bus.out_valid); end
    endtask

    task automatic test_reset_mid();
        logic [26:0] ex;
        int got = 0;
        int first = -1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            drive(1'b1, 24'h0F0F0F + 24'(c), 8'(c), 4'(c + 1));
        end
        @(negedge clk); #1;
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b want 1", bus.out_valid); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); end
        n_checks++; if (bus.out_sig !== 24'h0) begin n_fail++; $display("FAIL mid_rst_sig got %h want 0", bus.out_sig); end
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_rst_ready got %b want 1", bus.in_ready); end
        @(negedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk); #1;
            if (bus.out_valid) begin
                if (first < 0) first = c;
                ex = model(24'hC00000 >> got, 8'(got + 2));
                n_checks++;
                if ({bus.out_sig, bus.out_grs, bus.out_tag} !== {ex, 4'(4'hA + got)}) begin
                    n_fail++;
                    $display("FAIL mid_beat%0d got %h/%b/%h want %h/%b/%h", got, bus.out_sig, bus.out_grs, bus.out_tag, ex[26:3], ex[2:0], 4'(4'hA + got));
                end
                got++;
            end
            if (c < 3) drive(1'b1, 24'hC00000 >> c, 8'(c + 2), 4'(4'hA + c));
            else       bus.in_valid = 1'b0;
        end
        n_checks++; if (first !== 3) begin n_fail++; $display("FAIL mid_first got %0d want 3", first); end
        n_checks++; if (got !== 3) begin n_fail++; $display("FAIL mid_count got %0d want 3", got); end
    endtask

    initial begin
        bus.out_ready = 1'b1;
        drive(1'b0, 24'h0, 8'h0, 4'h0);
        test_reset();
        test_directed();
        test_back_to_back();
        test_stall();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/align_shifter.md
# align_shifter

Pipelined, parametrised right-alignment shifter for the floating-point adder datapath. It shifts the smaller operand's significand right by the exponent difference and produces guard, round and sticky bits for the rounding stage. It is the registered, flow-controlled successor to the combinational right shifter, and sits between exponent compare and significand add.

## Interface
- WIDTH, 24: significand width, including the hidden bit.
- SHAMT_W, 8: shift-amount width, matching the exponent difference.
- REG_EVERY, 2: number of shift stages per pipeline register. Range 1..NSTG.
- TAG_W, 4: width of the sideband tag carried alongside the data.
- Derived: NSTG = $clog2(WIDTH+3) and LAT = ceil(NSTG/REG_EVERY).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts the input beat.
- in_sig  in  WIDTH  significand to shift.
- in_shamt  in  SHAMT_W  right-shift amount (unsigned).
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_sig  out  WIDTH  shifted significand.
- out_grs  out  3  {guard, round, sticky}.
- out_tag  out  TAG_W  tag of this result.

## Operation
- Datapath word: {sig, g, r, s}, i.e. WIDTH+3 bits, initialised to {in_sig, 3'b000}.
- Stage k (k = 0..NSTG-1): if shamt[k] is set, shift right by 2^k.
  - Bits that fall below r are ORed into s.
  - s is never shifted out; it is only ORed into.
- Saturation is decided at input.
  - If in_shamt >= WIDTH+2: out_sig=0, g=0, r=0, s=|in_sig.
  - Bits of in_shamt at or above NSTG never reach the shift stages.
- Result is bit-exact to an infinite-precision shift: g = first discarded bit, r = second, s = OR of all remaining discarded bits.
- in_shamt=0 gives out_sig=in_sig and out_grs=000.
- The tag and the shift-amount bits still pending travel with the data through every register.
- Flow control is a global stall.
  - stall = out_valid & !out_ready.
  - in_ready = !stall.
  - On stall, all pipeline registers, including valids, hold.
  - Otherwise every stage advances, and bubbles propagate.
- Data registers do not require reset. Valid bits do.

## Timing
- Latency: an input accepted in cycle t appears at the output in cycle t+LAT when not stalled. Default latency is 3.
- Throughput: one beat per cycle while out_ready=1.
- Reset values: out_valid=0, in_ready=1. out_sig, out_grs and out_tag are 0 after reset.
- Reset asserted mid-operation: all in-flight beats are dropped immediately (asynchronous), with no partial output. The first accepted beat after deassertion emerges LAT cycles later.
- in_valid=1 while in_ready=0: the beat is not taken. The source must hold it.
- in_ready depends combinationally on out_ready. There is no other combinational path from input to output.
- Simultaneous output pop and input push in the same cycle is legal, including at full occupancy.

## Configuration
- ALIGN_SHIFT_STICKY_FULL_EN
  - Defined: sticky is the OR of all discarded bits below round, as described in Operation.
  - Undefined: legacy 3-bit GRS semantics.
    - s = the single discarded bit immediately below r; lower discarded bits are lost.
    - Saturated case: s = in_sig[in_shamt-3] when that index is in range, otherwise 0.
    - g and r are unchanged.

## Structure
- Package fp_pkg holds:
  - GRS bit indices: GRS_G=2, GRS_R=1, GRS_S=0.
  - A typedef for the {sig, grs, tag, shamt_rem, valid} stage record.
  - The function computing NSTG.
- One sub-module, align_shift_stage: a single conditional 2^k shift with sticky fold. It is instantiated NSTG times, with registers inserted at every REG_EVERY boundary.

## Test plan
- in_sig=0x800001, shamt=3 -> out_sig=0x100000, grs=001. shamt=0 with in_sig=0xABCDEF -> 0xABCDEF, grs=000.
- in_sig=0x000011, shamt=5: with the macro -> out_sig=0x000000, grs=101; without it -> grs=100.
- in_sig=0x000001, shamt=30 -> out_sig=0, grs=001. in_sig=0xFFFFFF, shamt=1 -> 0x7FFFFF, grs=100.
- Back-to-back stream of 16 random beats with out_ready=1 -> results in order, tags intact, first result at cycle t+3, one result per cycle.
- Hold out_ready=0 for 5 cycles with the pipeline full -> in_ready=0, outputs stable, no loss or duplication after release.
- Assert rst_n low mid-stream -> out_valid=0 at once. After release, only beats sent after reset appear.
